// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and defaults for the data-memory arbiter
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        MID_M0 = 1'b0,
        MID_M1 = 1'b1
    } mid_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick, pointer advances on each grant
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] i_req,
    input  logic       i_grant_en,
    output logic [1:0] o_gnt
);

    // 0: m0 wins a tie, 1: m1 wins a tie
    logic r_prio_m1;

    assign o_gnt[0] = i_req[0] & (~i_req[1] | ~r_prio_m1);
    assign o_gnt[1] = i_req[1] & (~i_req[0] |  r_prio_m1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prio_m1 <= 1'b0;
        end else if (i_grant_en && (o_gnt != 2'b00)) begin
            r_prio_m1 <= o_gnt[0];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU / debug-DMA arbiter for a shared data memory
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic        m0_sbyte,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_sbyte,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        mem_we,
    output logic        mem_sbyte,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // Highest word-aligned address whose four bytes still fit in memory
    localparam logic [ADDR_W-1:0] LO_MAX = {{(ADDR_W-2){1'b1}}, 2'b00};

    function automatic logic addr_err(input logic [31:0] addr, input logic sbyte);
        logic hi_bad;
        logic word_bad;
        hi_bad   = |(addr >> ADDR_W);
        word_bad = !sbyte && ((addr[1:0] != 2'b00) || (addr[ADDR_W-1:0] > LO_MAX));
        return hi_bad | word_bad;
    endfunction

    state_t      r_state;
    mid_t        r_mid;
    logic        r_we;
    logic        r_sbyte;
    logic        r_err;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_m0_ack;
    logic        r_m0_err;
    logic [31:0] r_m0_rdata;
    logic        r_m1_ack;
    logic        r_m1_err;
    logic [31:0] r_m1_rdata;

    logic [1:0]  w_gnt;
    logic        w_grant_en;
    logic        w_in_access;
    logic        w_sel_we;
    logic        w_sel_sbyte;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [31:0] w_resp_data;

    assign w_grant_en = (r_state == ST_IDLE);

    rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .rstn       (rstn),
        .i_req      ({m1_req, m0_req}),
        .i_grant_en (w_grant_en),
        .o_gnt      (w_gnt)
    );

    assign w_sel_we    = w_gnt[1] ? m1_we    : m0_we;
    assign w_sel_sbyte = w_gnt[1] ? m1_sbyte : m0_sbyte;
    assign w_sel_addr  = w_gnt[1] ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_gnt[1] ? m1_wdata : m0_wdata;

    // Writes and rejected accesses return zero data
    assign w_resp_data = (!r_we && !r_err) ? mem_rdata : 32'd0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_mid      <= MID_M0;
            r_we       <= 1'b0;
            r_sbyte    <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_m0_ack   <= 1'b0;
            r_m0_err   <= 1'b0;
            r_m0_rdata <= 32'd0;
            r_m1_ack   <= 1'b0;
            r_m1_err   <= 1'b0;
            r_m1_rdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt != 2'b00) begin
                        r_mid   <= w_gnt[1] ? MID_M1 : MID_M0;
                        r_we    <= w_sel_we;
                        r_sbyte <= w_sel_sbyte;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_err   <= addr_err(w_sel_addr, w_sel_sbyte);
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_mid == MID_M1) begin
                        r_m1_ack   <= 1'b1;
                        r_m1_err   <= r_err;
                        r_m1_rdata <= w_resp_data;
                    end else begin
                        r_m0_ack   <= 1'b1;
                        r_m0_err   <= r_err;
                        r_m0_rdata <= w_resp_data;
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_m0_ack   <= 1'b0;
                    r_m0_err   <= 1'b0;
                    r_m0_rdata <= 32'd0;
                    r_m1_ack   <= 1'b0;
                    r_m1_err   <= 1'b0;
                    r_m1_rdata <= 32'd0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_in_access = (r_state == ST_ACCESS);

    assign mem_we    = w_in_access & r_we & ~r_err;
    assign mem_sbyte = w_in_access & r_sbyte;
    assign mem_addr  = w_in_access ? r_addr  : 32'd0;
    assign mem_wdata = w_in_access ? r_wdata : 32'd0;

    assign m0_ack   = r_m0_ack;
    assign m0_err   = r_m0_err;
    assign m0_rdata = r_m0_rdata;
    assign m1_ack   = r_m1_ack;
    assign m1_err   = r_m1_err;
    assign m1_rdata = r_m1_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed vector bench for dmem_arbiter
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk;
    logic        rstn;
    logic        m0_req, m0_we, m0_sbyte;
    logic [31:0] m0_addr, m0_wdata;
    logic        m0_ack, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we, m1_sbyte;
    logic [31:0] m1_addr, m1_wdata;
    logic        m1_ack, m1_err;
    logic [31:0] m1_rdata;
    logic        mem_we, mem_sbyte;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    dmem_arbiter #(.ADDR_W(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_sbyte  (m0_sbyte),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_err    (m0_err),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_sbyte  (m1_sbyte),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_err    (m1_err),
        .m1_rdata  (m1_rdata),
        .mem_we    (mem_we),
        .mem_sbyte (mem_sbyte),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Little-endian byte memory; byte reads are zero-extended
    logic [7:0] mem [0:255];
    logic [7:0] a0, a1, a2, a3;
    assign a0 = mem_addr[7:0];
    assign a1 = a0 + 8'd1;
    assign a2 = a0 + 8'd2;
    assign a3 = a0 + 8'd3;
    assign mem_rdata = mem_sbyte ? {24'd0, mem[a0]} : {mem[a3], mem[a2], mem[a1], mem[a0]};

    always @(posedge clk) begin
        if (mem_we) begin
            mem[a0] <= mem_wdata[7:0];
            if (!mem_sbyte) begin
                mem[a1] <= mem_wdata[15:8];
                mem[a2] <= mem_wdata[23:16];
                mem[a3] <= mem_wdata[31:24];
            end
        end
    end

    typedef struct {
        bit          mst;
        bit          we;
        bit          sbyte;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_sbyte = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_sbyte = 0; m1_addr = 0; m1_wdata = 0;
    endtask

    task automatic drive(input bit mst, input bit we, input bit sbyte,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (mst) begin
            m1_req = 1; m1_we = we; m1_sbyte = sbyte; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = 1; m0_we = we; m0_sbyte = sbyte; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    task automatic do_access(input vec_t v, input int idx);
        int cyc;
        bit got;
        bit we_seen;
        cyc = 0; got = 0; we_seen = 0;
        @(negedge clk);
        drive(v.mst, v.we, v.sbyte, v.addr, v.wdata);
        while (!got && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (mem_we) we_seen = 1;
            if (v.mst ? m1_ack : m0_ack) got = 1;
        end
        chk($sformatf("v%0d latency", idx), cyc, 2);
        if (got) begin
            chk($sformatf("v%0d err", idx), v.mst ? m1_err : m0_err, v.exp_err);
            chk($sformatf("v%0d rdata", idx), v.mst ? m1_rdata : m0_rdata, v.exp_rdata);
            chk($sformatf("v%0d other ack", idx), v.mst ? m0_ack : m1_ack, 0);
            chk($sformatf("v%0d other rdata", idx), v.mst ? m0_rdata : m1_rdata, 0);
        end
        chk($sformatf("v%0d mem_we seen", idx), we_seen, v.we && !v.exp_err);
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        vt[0]  = '{0, 1, 0, 32'h10,        32'hDEADBEEF, 0, 32'h0};
        vt[1]  = '{0, 0, 0, 32'h10,        32'h0,        0, 32'hDEADBEEF};
        vt[2]  = '{1, 1, 0, 32'h20,        32'h11223344, 0, 32'h0};
        vt[3]  = '{1, 1, 1, 32'h21,        32'h123456AB, 0, 32'h0};
        vt[4]  = '{1, 0, 0, 32'h20,        32'h0,        0, 32'h1122AB44};
        vt[5]  = '{0, 0, 0, 32'h02,        32'h0,        1, 32'h0};
        vt[6]  = '{0, 0, 0, 32'hFD,        32'h0,        1, 32'h0};
        vt[7]  = '{1, 0, 1, 32'h100,       32'h0,        1, 32'h0};
        vt[8]  = '{0, 1, 0, 32'hFC,        32'hCAFEF00D, 0, 32'h0};
        vt[9]  = '{0, 0, 0, 32'hFC,        32'h0,        0, 32'hCAFEF00D};
        vt[10] = '{1, 0, 1, 32'hFF,        32'h0,        0, 32'h000000CA};
        vt[11] = '{0, 1, 0, 32'h1000_0010, 32'hFFFFFFFF, 1, 32'h0};
        vt[12] = '{1, 1, 0, 32'hFE,        32'h0BADF00D, 1, 32'h0};

        idle_inputs();
        rstn = 0;
        @(negedge clk);
        @(negedge clk);
        chk("reset outputs", {31'd0, m0_ack | m0_err | m1_ack | m1_err | mem_we | mem_sbyte}, 0);
        chk("reset rdata", m0_rdata | m1_rdata, 0);
        chk("reset mem bus", mem_addr | mem_wdata, 0);
        chk("reset state", dut.r_state, ST_IDLE);
        rstn = 1;

        for (int i = 0; i < 13; i++) do_access(vt[i], i);

        // Erroneous writes above must not have touched 0x10 or 0xFC
        do_access('{0, 0, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF}, 13);
        do_access('{1, 0, 0, 32'hFC, 32'h0, 0, 32'hCAFEF00D}, 14);

        // Requester drops req during ACCESS; ack must still arrive
        @(negedge clk);
        drive(0, 0, 0, 32'h20, 32'h0);
        @(negedge clk);
        m0_req = 0;
        @(negedge clk);
        chk("early drop ack", m0_ack, 1);
        chk("early drop rdata", m0_rdata, 32'h1122AB44);
        idle_inputs();
        @(negedge clk);

        // Reset while an m0 write is in ACCESS
        drive(0, 1, 0, 32'h40, 32'h55555555);
        @(negedge clk);
        chk("abort in access", dut.r_state, ST_ACCESS);
        chk("abort mem_we before reset", mem_we, 1);
        rstn = 0;
        m0_req = 0;
        #1;
        chk("abort state idle", dut.r_state, ST_IDLE);
        chk("abort bus zero", {mem_addr | mem_wdata}, 0);
        chk("abort mem_we zero", mem_we, 0);
        begin
            bit ack_seen;
            ack_seen = 0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (m0_ack || m1_ack) ack_seen = 1;
            end
            chk("abort no ack", ack_seen, 0);
        end
        rstn = 1;
        idle_inputs();
        do_access('{1, 0, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF}, 15);

        // Both masters hold req: grants alternate m0, m1, m0
        begin
            bit exp_m1 [3];
            int cyc;
            bit got;
            exp_m1[0] = 0; exp_m1[1] = 1; exp_m1[2] = 0;
            @(negedge clk);
            drive(0, 0, 0, 32'h10, 32'h0);
            drive(1, 0, 0, 32'h20, 32'h0);
            for (int k = 0; k < 3; k++) begin
                cyc = 0; got = 0;
                while (!got && cyc < 6) begin
                    @(negedge clk);
                    cyc++;
                    if (m0_ack && m1_ack) chk($sformatf("rr%0d dual ack", k), 1, 0);
                    if (m0_ack || m1_ack) got = 1;
                end
                chk($sformatf("rr%0d ack seen", k), got, 1);
                chk($sformatf("rr%0d latency", k), cyc, (k == 0) ? 2 : 3);
                if (got) begin
                    chk($sformatf("rr%0d winner", k), m1_ack, exp_m1[k]);
                    chk($sformatf("rr%0d rdata", k), m1_ack ? m1_rdata : m0_rdata,
                        exp_m1[k] ? 32'h1122AB44 : 32'hDEADBEEF);
                end
            end
            idle_inputs();
            @(negedge clk);
            @(negedge clk);
            chk("rr end idle", dut.r_state, ST_IDLE);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8: byte-address width of the shared data memory; addresses at or above 2**ADDR_W are out of range.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 m0_req / m1_req  input  1  access request from the CPU (m0) or debug/DMA (m1); held high until the matching ack.
REQ-005 m0_we / m1_we  input  1  1 = write, 0 = read; stable while req is high.
REQ-006 m0_sbyte / m1_sbyte  input  1  1 = byte access, 0 = 32-bit word access.
REQ-007 m0_addr / m1_addr  input  32  byte address.
REQ-008 m0_wdata / m1_wdata  input  32  write data; byte access uses bits [7:0].
REQ-009 m0_ack / m1_ack  output  1  one-cycle completion pulse.
REQ-010 m0_err / m1_err  output  1  valid with ack; 1 = access rejected, memory untouched.
REQ-011 m0_rdata / m1_rdata  output  32  read data, valid with ack; 0 on write or error.
REQ-012 mem_we, mem_sbyte  output  1 each  memory write enable and byte select.
REQ-013 mem_addr, mem_wdata  output  32 each  memory address and write data.
REQ-014 mem_rdata  input  32  combinational memory read data.

Function
REQ-015 FSM states: IDLE, ACCESS, RESP.
REQ-016 IDLE: no request -> stay; otherwise latch the winner's we/sbyte/addr/wdata and master id -> ACCESS.
REQ-017 Arbitration: one requester wins outright; if both request, the one not granted last wins (round-robin); after reset m0 has priority.
REQ-018 ACCESS, one cycle: drive mem_addr/mem_sbyte/mem_wdata from the latch; mem_we = latched we AND no error; capture mem_rdata (read, no error) into the response register -> RESP.
REQ-019 Error condition: addr[31:ADDR_W] nonzero, or word access with addr[1:0] != 0, or word access with addr[ADDR_W-1:0] > 2**ADDR_W-4 (no wrap-around); error -> mem_we stays 0 and rdata = 0.
REQ-020 RESP: pulse ack (and err if applicable) to the latched master only; drive rdata on that master's port, other port 0 -> IDLE.
REQ-021 Latency: req first seen high in IDLE at edge N -> memory access during cycle N+1 -> ack high during cycle N+2; one access per 3 cycles maximum.
REQ-022 A request arriving during ACCESS/RESP waits, with no loss, until the next IDLE.
REQ-023 A requester dropping req before ack: the latched access still completes and ack is still pulsed.
REQ-024 In RESP, the just-served master's still-high req is not treated as new; the next IDLE cycle rearbitrates.
REQ-025 Outside ACCESS: mem_we = 0; mem_addr, mem_wdata and mem_sbyte = 0.

Reset
REQ-026 rstn low: state = IDLE, round-robin pointer = m0 priority, all outputs and latches = 0, independent of clk.
REQ-027 Reset during ACCESS or RESP aborts the access; no ack is issued; any memory write already clocked is not undone.

Structure
REQ-028 Shared package dmem_arb_pkg contains the state enum, ADDR_W default and master-id encoding.
REQ-029 One sub-module, rr_arb2: 2-way round-robin pick with pointer update on grant.

Verification
REQ-030 m0 word write 0xDEADBEEF @0x10, then m0 word read @0x10 -> each ack 2 cycles after IDLE sample, rdata 0xDEADBEEF, err 0.
REQ-031 m0 and m1 both request in the same cycle, held, three times -> grants m0, m1, m0; no simultaneous acks.
REQ-032 m1 byte write 0x1234_56AB @0x21, then word read @0x20 -> byte 1 = 0xAB, other bytes unchanged.
REQ-033 Word read @0x02 and word read @0xFD, and byte read @0x100 -> ack with err 1, rdata 0, mem_we never high.
REQ-034 rstn low during ACCESS of an m0 write -> no m0_ack, state IDLE, outputs 0; new m1 read after release is served normally.
